// File: rtl/mem_sp_burst_ctrl_pkg.sv
// Shared definitions for the single-port RAM burst controller: stream
// direction codes, FSM state encoding and the address-width helper macro.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package mem_sp_burst_ctrl_pkg;

  localparam logic DIR_RD = 1'b0;
  localparam logic DIR_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_skid_buf2.sv
// Two-entry synchronous FIFO that absorbs read data already in flight from
// the RAM while the downstream stream is stalled.
module mem_skid_buf2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full buffer is only legal when the head leaves this cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_sp_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM: streams N words out of
// the RAM (hiding its 1-cycle read latency) or writes N streamed words into it.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

module mem_sp_burst_ctrl
  import mem_sp_burst_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = `CLOG2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [AW-1:0]    base,
  input  logic [AW:0]      len,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_di,
  input  logic [WIDTH-1:0] mem_do,
  output state_e           dbg_state
);

  // Streams: a beat transfers on the cycle where valid && ready are both high
  // at the rising clk edge; valid never depends combinationally on ready.

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   pop_cnt_q;
  logic          inflight_q;
  logic          busy_q;
  logic          done_q;

  logic          buf_full;
  logic          buf_empty;
  logic [1:0]    buf_count;
  logic          pop;
  logic [2:0]    room;
  logic          rd_issue;
  logic          wr_fire;
  logic [AW-1:0] addr_nxt;

  mem_skid_buf2 #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (mem_do),
    .pop_i   (pop),
    .data_o  (m_data),
    .full_o  (buf_full),
    .empty_o (buf_empty),
    .count_o (buf_count)
  );

  assign m_valid   = !buf_empty;
  assign pop       = m_valid && m_ready;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign mem_addr  = addr_q;
  assign mem_di    = s_data;

  always_comb begin
    // Words that will sit in the buffer next cycle if nothing new is issued.
    room     = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    rd_issue = (state_q == ST_RD) && (cnt_q < len_q) && (room < 3'd2)
               && !(buf_full && !pop);
    s_ready  = (state_q == ST_WR) && (cnt_q < len_q);
    wr_fire  = s_valid && s_ready;
    mem_en   = rd_issue || wr_fire;
    mem_we   = wr_fire;
    // DEPTH need not be a power of two, so wrap by compare rather than mask.
    addr_nxt = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      done_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q    <= base;
            len_q     <= len;
            cnt_q     <= '0;
            pop_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (len == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (dir == DIR_WR) begin
              state_q <= ST_WR;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (rd_issue) begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_nxt;
          end
          if (pop) begin
            pop_cnt_q <= pop_cnt_q + 1'b1;
            if (pop_cnt_q + 1'b1 == len_q) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_WR: begin
          if (wr_fire) begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_nxt;
          end else if (cnt_q == len_q) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sp_burst_ctrl.sv
// Bench for mem_sp_burst_ctrl wired to a write-first single-port RAM model;
// a negedge monitor checks stream beats and RAM accesses against queues.
module tb_mem_sp_burst_ctrl;
  import mem_sp_burst_ctrl_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 48;
  localparam int AW    = 6;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             dir;
  logic [AW-1:0]    base;
  logic [AW:0]      len;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [AW-1:0]    mem_addr;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_di;
  logic [WIDTH-1:0] mem_do;
  state_e           dbg_state;

  logic             pl_en;
  logic [AW-1:0]    pl_addr;
  logic [WIDTH-1:0] pl_data;
  logic [WIDTH-1:0] ram [DEPTH];

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0]    exp_q[$];
  logic [AW-1:0]       raddr_q[$];
  logic [AW+WIDTH-1:0] wexp_q[$];
  logic [WIDTH-1:0]    model [DEPTH];
  logic [WIDTH-1:0]    wdata [DEPTH];
  int   outstanding;
  logic mon_pop;
  logic mon_rd;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mem_sp_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_di    (mem_di),
    .mem_do    (mem_do),
    .dbg_state (dbg_state)
  );

  // single-port RAM, write-first, registered output that holds while en=0
  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_di;
        mem_do        <= mem_di;
      end else begin
        mem_do <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      raddr_q.delete();
      wexp_q.delete();
      outstanding = 0;
    end else begin
      mon_pop = m_valid && m_ready;
      mon_rd  = mem_en && !mem_we;
      if (mon_rd) begin
        checks++;
        if (outstanding - int'(mon_pop) >= 2) begin
          errors++;
          $display("FAIL rd_room: issue with %0d outstanding, pop=%0d, required < 2 after pop",
                   outstanding, mon_pop);
        end
        if (raddr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_addr_extra: read issued at addr %0d, none expected", mem_addr);
        end else begin
          chk("rd_addr", int'(mem_addr), int'(raddr_q.pop_front()));
        end
      end
      if (mem_en && mem_we) begin
        if (wexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_extra: write at addr %0d data 0x%0h, none expected", mem_addr, mem_di);
        end else begin
          chk("wr_addr_data", int'({mem_addr, mem_di}), int'(wexp_q.pop_front()));
        end
      end
      if ((mem_en && mem_we) || (s_valid && s_ready)) begin
        chk("wr_only_on_handshake", int'(mem_en && mem_we), int'(s_valid && s_ready));
      end
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_beat_extra: beat 0x%0h, none expected", m_data);
        end else begin
          chk("rd_data", int'(m_data), int'(exp_q.pop_front()));
        end
      end
      outstanding = outstanding + int'(mon_rd) - int'(mon_pop);
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input logic d, input int b, input int l, input int mode,
                           output int done_n, output int fv, output int vcnt);
    int   idx;
    int   n;
    int   gap;
    int   a;
    logic hs;
    idx = 0;
    n   = 0;
    gap = 0;
    for (int i = 0; i < l; i++) begin
      a = (b + i) % DEPTH;
      if (d == DIR_WR) begin
        wexp_q.push_back({AW'(a), wdata[i]});
        model[a] = wdata[i];
      end else begin
        raddr_q.push_back(AW'(a));
        exp_q.push_back(model[a]);
      end
    end
    start = 1'b1;
    dir   = d;
    base  = AW'(b);
    len   = (AW+1)'(l);
    step();
    start = 1'b0;
    fv    = -1;
    vcnt  = 0;
    while (!done && n < 400) begin
      if (m_valid) begin
        vcnt++;
        if (fv < 0) fv = n;
      end
      if (d == DIR_WR) begin
        s_valid = (idx < l) && (gap == 0);
        s_data  = (idx < l) ? wdata[idx] : '0;
      end else begin
        m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      hs = s_valid && s_ready;
      step();
      n++;
      if (hs) begin
        idx++;
        if (mode == 1) gap = $urandom_range(1, 3);
      end else if (gap > 0) begin
        gap--;
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL burst_timeout: no done within %0d cycles (base %0d len %0d)", n, b, l);
    end
    done_n = n;
  endtask

  task automatic preload_addr_as_data();
    for (int i = 0; i < DEPTH; i++) begin
      pl_en   = 1'b1;
      pl_addr = AW'(i);
      pl_data = WIDTH'(i);
      model[i] = WIDTH'(i);
      step();
    end
    pl_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"},     int'(busy),      0);
    chk({tag, "_done"},     int'(done),      0);
    chk({tag, "_m_valid"},  int'(m_valid),   0);
    chk({tag, "_s_ready"},  int'(s_ready),   0);
    chk({tag, "_mem_en"},   int'(mem_en),    0);
    chk({tag, "_mem_we"},   int'(mem_we),    0);
    chk({tag, "_mem_addr"}, int'(mem_addr),  0);
    chk({tag, "_state"},    int'(dbg_state), int'(ST_IDLE));
  endtask

  // stimulus
  initial begin
    int dn;
    int fv;
    int vc;
    rst_n   = 1'b0;
    start   = 1'b0;
    dir     = 1'b0;
    base    = '0;
    len     = '0;
    m_ready = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    step();

    // write burst base 5 len 4, s_valid held
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33; wdata[3] = 8'h44;
    run_burst(DIR_WR, 5, 4, 0, dn, fv, vc);
    chk("wr_done_latency", dn, 5);
    chk("wr_busy_in_done", int'(busy), 1);
    start = 1'b1;  // ignored in the DONE cycle
    dir   = DIR_RD;
    len   = 7'd3;
    step();
    start = 1'b0;
    chk("wr_busy_after_done", int'(busy), 0);
    chk("start_in_done_ignored", int'(dbg_state), int'(ST_IDLE));
    chk("ram5", int'(ram[5]), 8'h11);
    chk("ram6", int'(ram[6]), 8'h22);
    chk("ram7", int'(ram[7]), 8'h33);
    chk("ram8", int'(ram[8]), 8'h44);

    // read burst base 5 len 4, no backpressure
    run_burst(DIR_RD, 5, 4, 0, dn, fv, vc);
    chk("rd_first_valid", fv, 2);
    chk("rd_valid_beats", vc, 4);
    chk("rd_done_latency", dn, 6);
    chk("rd_no_missing", exp_q.size(), 0);
    step();

    // full-depth read under random backpressure
    preload_addr_as_data();
    run_burst(DIR_RD, 0, DEPTH, 1, dn, fv, vc);
    chk("bp_no_missing", exp_q.size(), 0);
    step();

    // wrap-around write and read
    wdata[0] = 8'hC1; wdata[1] = 8'hC2; wdata[2] = 8'hC3; wdata[3] = 8'hC4;
    run_burst(DIR_WR, 46, 4, 0, dn, fv, vc);
    chk("wrap_wr_done", dn, 5);
    step();
    chk("ram46", int'(ram[46]), 8'hC1);
    chk("ram1",  int'(ram[1]),  8'hC4);
    run_burst(DIR_RD, 46, 4, 0, dn, fv, vc);
    chk("wrap_rd_done", dn, 6);
    chk("wrap_rd_no_missing", exp_q.size(), 0);
    step();

    // zero-length burst
    run_burst(DIR_RD, 10, 0, 0, dn, fv, vc);
    chk("len0_done", dn, 0);
    step();
    chk("len0_idle", int'(dbg_state), int'(ST_IDLE));

    // write with s_valid gaps
    for (int i = 0; i < 6; i++) wdata[i] = 8'hA0 + WIDTH'(i);
    run_burst(DIR_WR, 20, 6, 1, dn, fv, vc);
    step();
    chk("stall_ram20", int'(ram[20]), 8'hA0);
    chk("stall_ram22", int'(ram[22]), 8'hA2);
    chk("stall_ram25", int'(ram[25]), 8'hA5);
    chk("stall_wr_all", wexp_q.size(), 0);
    run_burst(DIR_RD, 20, 6, 1, dn, fv, vc);
    chk("stall_rd_no_missing", exp_q.size(), 0);
    step();

    // reset mid-burst with two words buffered
    for (int i = 0; i < 10; i++) begin
      raddr_q.push_back(AW'(i));
      exp_q.push_back(model[i]);
    end
    start = 1'b1;
    dir   = DIR_RD;
    base  = '0;
    len   = 7'd10;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid_m_valid", int'(m_valid), 1);
    chk("mid_mem_en_held", int'(mem_en), 0);
    rst_n = 1'b0;
    step();
    check_idle_outputs("midrst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_done", int'(done), 0);
    end
    run_burst(DIR_RD, 5, 4, 0, dn, fv, vc);
    chk("post_rst_done", dn, 6);
    chk("post_rst_no_missing", exp_q.size(), 0);
    step();

    chk("end_raddr_q_empty", raddr_q.size(), 0);
    chk("end_wexp_q_empty", wexp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_sp_burst_ctrl.md
Name: mem_sp_burst_ctrl

Overview:
- Initiator-side controller for a single-ported synchronous RAM: owns the RAM's clk-domain address/en/we/di pins and consumes its registered read-data output.
- Executes one burst per command: read N words from the RAM onto a valid/ready stream, or write N words from a valid/ready stream into the RAM.
- Sits between the ROLLO decrypt datapath engines and each coefficient RAM. Hides the RAM's 1-cycle read latency and downstream backpressure.

Parameters:
- WIDTH, 8, data word width; must match the RAM.
- DEPTH, 64, RAM depth in words; need not be a power of 2.
- AW, CLOG2(DEPTH), address width; derived, not overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  command strobe; sampled only in IDLE.
- dir  in  1  0 = read burst (RAM to stream), 1 = write burst (stream to RAM).
- base  in  AW  first RAM address of the burst.
- len  in  AW+1  burst length in words, 0..DEPTH.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the burst completes.
- m_data  out  WIDTH  read stream data.
- m_valid  out  1  read stream valid.
- m_ready  in  1  read stream ready.
- s_data  in  WIDTH  write stream data.
- s_valid  in  1  write stream valid.
- s_ready  out  1  write stream ready.
- mem_addr  out  AW  to RAM addr.
- mem_en  out  1  to RAM en.
- mem_we  out  1  to RAM we.
- mem_di  out  WIDTH  to RAM di.
- mem_do  in  WIDTH  from RAM do. Registered; valid the cycle after a read with en=1; holds its value while en=0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state goes to IDLE; busy, done, m_valid, s_ready, mem_en and mem_we are 0; mem_addr is 0; the skid buffer is emptied.
- Reset mid-burst aborts the burst: no done pulse, and buffered data is discarded.
- States are IDLE, RD, WR and DONE.
- IDLE:
  - start=1 latches base, len and dir. Next state is RD or WR.
  - len=0 goes straight to DONE.
  - start in any other state is ignored. No queuing.
- Address sequencing:
  - Address counter starts at base and increments per issued access.
  - The step after DEPTH-1 is 0 (explicit compare, not a mask).
  - A burst with len=DEPTH touches every word exactly once.
- RD:
  - Issue rule: assert mem_en=1, mem_we=0 when issued < len AND (buffer occupancy + reads in flight − pop this cycle) < 2.
  - The 2-entry buffer captures mem_do in the cycle after each issue.
  - m_data/m_valid are driven from the buffer head. Pop on m_valid&&m_ready.
  - No read data is ever dropped or duplicated under any m_ready pattern.
  - Timing: start accepted at edge E0 → first mem_en in the cycle after E0 → m_valid first high 2 cycles after E0.
  - With m_ready held 1, throughput is 1 word/cycle.
  - Leave RD for DONE in the cycle after the final stream handshake.
- WR:
  - s_ready=1 while written < len.
  - On s_valid&&s_ready, in the same cycle: mem_en=1, mem_we=1, mem_di=s_data, mem_addr=current address. Zero added latency.
  - mem_en=0 when there is no handshake.
  - Leave WR for DONE after the len-th write.
- DONE: done=1 for one cycle, busy=1, then IDLE. A start in the DONE cycle is ignored.
- Outside RD/WR: mem_en=0 and mem_we=0. mem_di is don't-care when we=0.
- Counters are AW+1 bits wide, so len=DEPTH does not overflow.

Decomposition:
- Shared package/define file holds:
  - DIR_RD=0 and DIR_WR=1;
  - the state encodings;
  - the CLOG2 macro, from the existing shared include.
- One sub-module, mem_skid_buf2: a 2-entry synchronous FIFO (WIDTH, push/pop/full/empty/count) used on the read path.
- Bench instantiates this controller wired to the existing single-port RAM model (write-first mode).

Test Plan:
- Write burst: base=5, len=4, s_data 0x11,0x22,0x33,0x44 with s_valid held 1 → RAM[5..8] = 0x11..0x44, done 5 cycles after start edge, busy low after done.
- Read burst, no backpressure: base=5, len=4, m_ready=1 → m_data 0x11,0x22,0x33,0x44 on consecutive cycles starting 2 cycles after start edge; done the cycle after the last handshake.
- Read under random backpressure: m_ready toggled pseudo-randomly, len=DEPTH, RAM preloaded with addr-as-data → stream is exactly 0..DEPTH-1 in order. No extra or missing beats; mem_en never fires with 2 words buffered and none popping.
- Wrap-around: DEPTH=48 build, base=46, len=4 → addresses 46,47,0,1 on both read and write; len=0 → done pulse 1 cycle after start, no mem_en.
- Write stall: s_valid gaps of 1–3 cycles → mem_en/mem_we high only on handshake cycles, addresses contiguous, RAM contents correct.
- Reset mid-burst: rst_n=0 during RD with 2 words buffered → next cycle all outputs 0 and state IDLE, no done. A following read burst returns correct data with no stale beats.
